mult_div_unit: RTL and testbench

Multiply/divide unit of the EX stage in the P6 pipelined MIPS CPU. Executes mult/multu/div/divu with fixed multi-cycle latency into architectural HI/LO registers, serves mfhi/mflo reads combinationally and mthi/mtlo writes in one cycle. Its read result joins the EX result path that feeds the MEM stage. It exports `busy` so the hazard unit can stall dependent MD instructions in D.

---
 rtl/mdu_pkg.sv | 37 +++
 rtl/md_arith.sv | 66 ++++++
 rtl/mult_div_unit.sv | 96 +++++++++
 tb/tb_mult_div_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, default latencies, FSM states.
// Optional MDU_MADD_EN adds MADD/MADDU to the multiply-latency op set.
package mdu_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;
  localparam logic [3:0] MD_MADD  = 4'd9;
  localparam logic [3:0] MD_MADDU = 4'd10;

  localparam int DEFAULT_MULT_CYCLES = 5;
  localparam int DEFAULT_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return op inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU};
`else
    return op inside {MD_MULT, MD_MULTU};
`endif
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational result generator for multi-cycle MD ops; a zero divisor returns the current {HI,LO}.
// With MDU_MADD_EN defined, also produces the MADD/MADDU accumulate result.
module md_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [63:0] o_result
);

  logic [63:0] w_smul;
  logic [63:0] w_umul;
  logic        w_a_neg;
  logic        w_b_neg;
  logic        w_b_zero;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_uns;
  logic [31:0] w_squo;
  logic [31:0] w_srem;
  logic [31:0] w_uquo;
  logic [31:0] w_urem;
  logic [31:0] w_quo_s;
  logic [31:0] w_rem_s;

  // Sign-extend to 64 bits so the low half of the product is the exact two's-complement result.
  assign w_smul = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_umul = {32'd0, i_a} * {32'd0, i_b};

  assign w_b_zero = (i_b == 32'd0);
  assign w_a_neg  = i_a[31];
  assign w_b_neg  = i_b[31];

  // Signed divide runs on magnitudes, so INT_MIN / -1 wraps cleanly instead of overflowing.
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_zero ? 32'd1 : (w_b_neg ? -i_b : i_b);
  assign w_b_uns = w_b_zero ? 32'd1 : i_b;

  assign w_squo  = w_a_mag / w_b_mag;
  assign w_srem  = w_a_mag % w_b_mag;
  assign w_uquo  = i_a / w_b_uns;
  assign w_urem  = i_a % w_b_uns;

  assign w_quo_s = (w_a_neg ^ w_b_neg) ? -w_squo : w_squo;
  assign w_rem_s = w_a_neg ? -w_srem : w_srem;

  always_comb begin
    // NOTE: default assignment first so every path drives o_result and no latch is inferred.
    o_result = {i_hi, i_lo};
    case (i_op)
      MD_MULT:  o_result = w_smul;
      MD_MULTU: o_result = w_umul;
      MD_DIV:   if (!w_b_zero) o_result = {w_rem_s, w_quo_s};
      MD_DIVU:  if (!w_b_zero) o_result = {w_urem, w_uquo};
`ifdef MDU_MADD_EN
      MD_MADD:  o_result = {i_hi, i_lo} + w_smul;
      MD_MADDU: o_result = {i_hi, i_lo} + w_umul;
`endif
      default:  ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: fixed-latency IDLE/RUN FSM committing into architectural HI/LO.
// MDU_MADD_EN enables MADD/MADDU (multiply latency, accumulate into {HI,LO}).
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  mdu_state_e  r_state;
  logic [3:0]  r_cnt;
  logic [63:0] r_pending;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_is_long;
  logic [3:0]  w_latency;
  logic [63:0] w_result;

  assign w_is_mul  = is_mul_op(MDOp);
  assign w_is_div  = is_div_op(MDOp);
  assign w_is_long = w_is_mul | w_is_div;
  assign w_latency = w_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

  md_arith u_md_arith (
    .i_op     (MDOp),
    .i_a      (A),
    .i_b      (B),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .o_result (w_result)
  );

  // NOTE: non-blocking assignments throughout, so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_pending <= 64'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_is_long) begin
              r_pending <= w_result;
              r_cnt     <= w_latency;
              r_state   <= ST_RUN;
            end else if (MDOp == MD_MTHI) begin
              r_hi <= A;
            end else if (MDOp == MD_MTLO) begin
              r_lo <= A;
            end
          end
        end
        ST_RUN: begin
          // Commit on the edge where the counter reads 1: busy drops as HI/LO update.
          if (r_cnt <= 4'd1) begin
            r_hi    <= r_pending[63:32];
            r_lo    <= r_pending[31:0];
            r_cnt   <= 4'd0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state == ST_RUN);
  assign HI   = r_hi;
  assign LO   = r_lo;

  always_comb begin
    MDOut = 32'd0;
    if (MDOp == MD_MFHI)      MDOut = r_hi;
    else if (MDOp == MD_MFLO) MDOut = r_lo;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: driver queues expected HI/LO/latency, monitor checks on busy fall.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;
  localparam int IDLE_LIMIT = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDOut;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] c_hi;
  logic [31:0] c_lo;
  int          n_checks = 0;
  int          n_err = 0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO),
    .MDOut (MDOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from the architectural rules, using 64-bit integer arithmetic.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo,
                       output bit is_long, output int len,
                       output logic [31:0] nhi, output logic [31:0] nlo);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     t;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    is_long = 0;
    len = 0;
    nhi = hi;
    nlo = lo;
    case (op)
      4'd1: begin t = sa * sb; {nhi, nlo} = t; is_long = 1; len = MC; end
      4'd2: begin t = ua * ub; {nhi, nlo} = t; is_long = 1; len = MC; end
      4'd3: begin
        is_long = 1; len = DC;
        if (b != 0) begin
          sq = sa / sb; sr = sa % sb;
          t = sq; nlo = t[31:0];
          t = sr; nhi = t[31:0];
        end
      end
      4'd4: begin
        is_long = 1; len = DC;
        if (b != 0) begin
          t = ua / ub; nlo = t[31:0];
          t = ua % ub; nhi = t[31:0];
        end
      end
      4'd7: nhi = a;
      4'd8: nlo = a;
`ifdef MDU_MADD_EN
      4'd9:  begin t = sa * sb; {nhi, nlo} = {hi, lo} + t; is_long = 1; len = MC; end
      4'd10: begin t = ua * ub; {nhi, nlo} = {hi, lo} + t; is_long = 1; len = MC; end
`endif
      default: ;
    endcase
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || exp_q.size() != 0) && k < IDLE_LIMIT) begin
      @(negedge clk);
      k++;
    end
    if (k >= IDLE_LIMIT) check("idle_wait_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit          lng;
    int          len;
    logic [31:0] nh, nl;
    wait_idle();
    model(op, a, b, c_hi, c_lo, lng, len, nh, nl);
    start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
    #1;
    if (op == MD_MFHI)      check("mfhi_out", MDOut, c_hi);
    else if (op == MD_MFLO) check("mflo_out", MDOut, c_lo);
    else                    check("mdout_zero", MDOut, 0);
    if (lng) exp_q.push_back('{nh, nl, len});
    @(negedge clk);
    start = 1'b0;
    MDOp  = MD_NONE;
    if (!lng) begin
      check("short_op_busy", busy, 0);
      check("short_op_hi", HI, nh);
      check("short_op_lo", LO, nl);
      c_hi = nh;
      c_lo = nl;
    end
  endtask

  // Drive a start without waiting for idle and without touching the model.
  task automatic issue_raw(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    MDOp  = MD_NONE;
  endtask

  // Monitor: HI/LO must hold while busy; on busy fall, pop and compare result and busy length.
  initial begin
    bit   prev_busy = 0;
    int   cnt = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        prev_busy = 0;
        cnt = 0;
      end else begin
        if (busy) begin
          cnt++;
          check("hold_hi", HI, c_hi);
          check("hold_lo", LO, c_lo);
        end else if (prev_busy) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_done: busy fell with no pending op at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("busy_len", cnt, e.len);
            check("result_hi", HI, e.hi);
            check("result_lo", LO, e.lo);
            c_hi = e.hi;
            c_lo = e.lo;
          end
          cnt = 0;
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] ra, rb;
    reset = 1'b1;
    start = 1'b0;
    MDOp  = MD_NONE;
    A     = 32'd0;
    B     = 32'd0;
    c_hi  = 32'd0;
    c_lo  = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_hi", HI, 0);
    check("reset_lo", LO, 0);
    check("reset_mdout", MDOut, 0);
    reset = 1'b0;
    @(negedge clk);

    issue(MD_MULT,  32'hFFFF_FFFF, 32'd2);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    issue(MD_DIV,   32'hFFFF_FFF9, 32'd2);
    issue(MD_DIVU,  32'd7,         32'd0);
    wait_idle();
    check("divu_zero_hi", HI, 32'hFFFF_FFFF);
    check("divu_zero_lo", LO, 32'hFFFF_FFFD);

    issue(MD_MTHI, 32'h1234_5678, 32'd0);
    issue(MD_MFHI, 32'd0, 32'd0);
    issue(MD_MFLO, 32'd0, 32'd0);

    issue(MD_DIV, 32'd100, 32'd7);
    @(negedge clk);
    issue_raw(MD_MTLO, 32'hDEAD_BEEF, 32'd0);
    wait_idle();
    check("mtlo_ignored_lo", LO, 32'd14);
    check("mtlo_ignored_hi", HI, 32'd2);

    // Reset at busy cycle 3 of MULT 3*4 discards the pending product.
    issue(MD_MULT, 32'd3, 32'd4);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    c_hi = 32'd0;
    c_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_hi", HI, 0);
    check("rst_mid_lo", LO, 0);
    repeat (8) @(negedge clk);
    check("rst_mid_lo_later", LO, 0);

    issue(MD_MTLO, 32'h0BAD_F00D, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    MDOp  = MD_MULT;
    A     = 32'd5;
    B     = 32'd6;
    c_hi  = 32'd0;
    c_lo  = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    MDOp  = MD_NONE;
    check("rst_start_busy", busy, 0);
    check("rst_start_lo", LO, 0);
    repeat (3) @(negedge clk);
    check("rst_start_busy_later", busy, 0);

    issue(MD_MTHI, 32'd0, 32'd0);
    issue(MD_MTLO, 32'hFFFF_FFFF, 32'd0);
    issue(MD_MADDU, 32'd1, 32'd1);
    wait_idle();
`ifdef MDU_MADD_EN
    check("maddu_hi", HI, 32'd1);
    check("maddu_lo", LO, 32'd0);
`else
    check("maddu_nop_hi", HI, 32'd0);
    check("maddu_nop_lo", LO, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = $urandom_range(1, 9);
        default: ;
      endcase
      issue(op, ra, rb);
    end
    wait_idle();
    check("final_hi", HI, c_hi);
    check("final_lo", LO, c_lo);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
